// File: rtl/div_32by16_signed_if.sv
// Handshake and data bundle for the sequential 32/16 signed divider.
// The slave side is the divider; the master side is the producer/consumer.
interface div_32by16_signed_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        overflow;
    logic        div_by_zero;

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, overflow, div_by_zero
    );

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, overflow, div_by_zero
    );
endinterface

// File: rtl/div_32by16_signed.sv
// Sequential signed divider: 32-bit dividend by 16-bit divisor, one restoring
// step per clock on magnitudes, signs applied in a final FIX cycle.
module div_32by16_signed (
    input  logic                   clk,
    input  logic                   rst,
    div_32by16_signed_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] dmag_q, dmag_d;
    logic [15:0] vmag_q, vmag_d;
    logic [15:0] prem_q, prem_d;
    logic [31:0] qmag_q, qmag_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] quot_q, quot_d;
    logic [15:0] rem_q, rem_d;
    logic        ovf_q, ovf_d;
    logic        dbz_q, dbz_d;
    logic [16:0] step_res;

    function automatic logic [31:0] mag32(input logic signed [31:0] x);
        return x[31] ? 32'(-x) : x;
    endfunction

    function automatic logic [15:0] mag16(input logic signed [15:0] x);
        return x[15] ? 16'(-x) : x;
    endfunction

    function automatic logic [15:0] apply_sign16(input logic neg, input logic [15:0] m);
        return neg ? 16'(-m) : m;
    endfunction

    // Returns {quotient bit, new partial remainder}; the remainder always
    // fits 16 bits because it stays below the divisor magnitude (<= 32768).
    function automatic logic [16:0] restore_step(input logic [15:0] prem,
                                                 input logic        next_bit,
                                                 input logic [15:0] vmag);
        logic [16:0] shifted;
        shifted = {prem, next_bit};
        if (shifted >= {1'b0, vmag})
            return {1'b1, 16'(shifted - {1'b0, vmag})};
        return {1'b0, shifted[15:0]};
    endfunction

    assign step_res = restore_step(prem_q, dmag_q[31], vmag_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dmag_q  <= '0;
            vmag_q  <= '0;
            prem_q  <= '0;
            qmag_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dmag_q  <= dmag_d;
            vmag_q  <= vmag_d;
            prem_q  <= prem_d;
            qmag_q  <= qmag_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dmag_d  = dmag_q;
        vmag_d  = vmag_q;
        prem_d  = prem_q;
        qmag_d  = qmag_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    dmag_d  = mag32(bus.dividend);
                    vmag_d  = mag16(bus.divisor);
                    qneg_d  = bus.dividend[31] ^ bus.divisor[15];
                    rneg_d  = bus.dividend[31];
                    prem_d  = '0;
                    qmag_d  = '0;
                    cnt_d   = '0;
                    state_d = (bus.divisor != 16'd0) ? CALC : FIX;
                end
            end
            CALC: begin
                prem_d = step_res[15:0];
                qmag_d = {qmag_q[30:0], step_res[16]};
                dmag_d = {dmag_q[30:0], 1'b0};
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31)
                    state_d = FIX;
            end
            FIX: begin
                if (vmag_q == 16'd0) begin
                    // Untouched dividend magnitude re-signed gives back its low bits.
                    quot_d = 16'hFFFF;
                    rem_d  = apply_sign16(rneg_q, dmag_q[15:0]);
                    ovf_d  = 1'b0;
                    dbz_d  = 1'b1;
                end else begin
                    quot_d = apply_sign16(qneg_q, qmag_q[15:0]);
                    rem_d  = apply_sign16(rneg_q, prem_q);
                    ovf_d  = qneg_q ? (qmag_q > 32'd32768) : (qmag_q > 32'd32767);
                    dbz_d  = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.overflow    = ovf_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_div_32by16_signed.sv
// Directed and round-trip bench for div_32by16_signed with a reference model
// based on native signed division.
module tb_div_32by16_signed;
    logic clk;
    logic rst;
    div_32by16_signed_if bus ();

    div_32by16_signed dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    bit          exp_vld = 1'b0;
    logic [15:0] exp_q, exp_r;
    logic        exp_ovf, exp_dbz;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model(input logic [31:0] a, input logic [15:0] b,
                         output logic [15:0] q, output logic [15:0] r,
                         output logic o, output logic z);
        longint sa, sb, lq, lr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) begin
            q = 16'hFFFF; r = a[15:0]; o = 1'b0; z = 1'b1;
        end else begin
            lq = sa / sb;
            lr = sa % sb;
            q = lq[15:0]; r = lr[15:0];
            o = (lq > 32767) || (lq < -32768);
            z = 1'b0;
        end
    endtask

    task automatic pin_model(input string nm, input logic [31:0] a, input logic [15:0] b,
                             input logic [15:0] q, input logic [15:0] r,
                             input logic o, input logic z);
        logic [15:0] mq, mr;
        logic mo, mz;
        model(a, b, mq, mr, mo, mz);
        check({nm, "_model_q"}, {16'd0, mq}, {16'd0, q});
        check({nm, "_model_r"}, {16'd0, mr}, {16'd0, r});
        check({nm, "_model_flags"}, {30'd0, mo, mz}, {30'd0, o, z});
    endtask

    // Output compare against the model on every cycle a result is presented.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.in_ready && bus.out_valid)
                check("ready_and_valid", 32'd1, 32'd0);
            if (bus.out_valid) begin
                if (!exp_vld) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    check("quotient", {16'd0, bus.quotient}, {16'd0, exp_q});
                    check("remainder", {16'd0, bus.remainder}, {16'd0, exp_r});
                    check("overflow", {31'd0, bus.overflow}, {31'd0, exp_ovf});
                    check("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, exp_dbz});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!bus.in_ready) check("wait_in_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic accept(input logic [31:0] a, input logic [15:0] b);
        model(a, b, exp_q, exp_r, exp_ovf, exp_dbz);
        wait_ready();
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        exp_vld      = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = 16'($urandom);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [15:0] b, input int hold);
        int lat;
        accept(a, b);
        lat = 0;
        while (!bus.out_valid && lat < 60) begin
            tick();
            lat++;
        end
        check("latency", lat, (b == 16'd0) ? 32'd1 : 32'd33);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'($urandom);
            bus.dividend = $urandom;
            bus.divisor  = 16'($urandom);
            tick();
            check("hold_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
            check("hold_out_valid_high", {31'd0, bus.out_valid}, 32'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        exp_vld       = 1'b0;
        check("in_ready_after_handshake", {31'd0, bus.in_ready}, 32'd1);
        check("out_valid_after_handshake", {31'd0, bus.out_valid}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        check({nm, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        check({nm, "_q"}, {16'd0, bus.quotient}, 32'd0);
        check({nm, "_r"}, {16'd0, bus.remainder}, 32'd0);
        check({nm, "_flags"}, {30'd0, bus.overflow, bus.div_by_zero}, 32'd0);
    endtask

    initial begin
        logic signed [15:0] ra, rb;
        logic signed [31:0] prod;
        logic [15:0] mq, mr;
        logic mo, mz;
        int rt_fail_before;

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        pin_model("p100_7", 32'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0);
        pin_model("pm100_7", -32'sd100, 16'd7, -16'sd14, -16'sd2, 1'b0, 1'b0);
        pin_model("p100_m7", 32'd100, -16'sd7, -16'sd14, 16'd2, 1'b0, 1'b0);
        pin_model("povf1", 32'd1000000, -16'sd3, 16'hE9EB, 16'd1, 1'b1, 1'b0);
        pin_model("povf2", 32'h80000000, 16'hFFFF, 16'h0000, 16'd0, 1'b1, 1'b0);
        pin_model("pdbz", 32'd1234, 16'd0, 16'hFFFF, 16'h04D2, 1'b0, 1'b1);

        run_op(32'd100, 16'd7, 0);
        run_op(-32'sd100, 16'd7, 0);
        run_op(32'd100, -16'sd7, 0);
        run_op(32'd1000000, -16'sd3, 10);
        run_op(32'h80000000, 16'hFFFF, 0);
        run_op(32'd1234, 16'd0, 3);
        run_op(-32'sd1234, 16'd0, 0);

        // Reset while the divider is mid-way through its iterations.
        accept(32'd100, 16'd7);
        for (int i = 0; i < 16; i++) tick();
        check("midcalc_busy", {31'd0, bus.in_ready}, 32'd0);
        rst = 1'b1;
        exp_vld = 1'b0;
        tick();
        rst = 1'b0;
        check_reset_outputs("midreset");
        for (int i = 0; i < 40; i++) tick();
        check("midreset_no_result", {31'd0, bus.out_valid}, 32'd0);
        run_op(32'd100, 16'd7, 0);

        rt_fail_before = fails;
        for (int k = 0; k < 103; k++) begin
            if (k == 0) begin ra = -16'sd32768; rb = -16'sd1; end
            else if (k == 1) begin ra = 16'sd32767; rb = 16'sd32767; end
            else if (k == 2) begin ra = -16'sd32768; rb = 16'sd1; end
            else begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                if (rb == 16'sd0) rb = 16'sd3;
            end
            prod = ra * rb;
            model(prod, rb, mq, mr, mo, mz);
            check("rt_model_q", {16'd0, mq}, {16'd0, ra});
            check("rt_model_r", {16'd0, mr}, 32'd0);
            check("rt_model_ovf", {31'd0, mo}, 32'd0);
            run_op(prod, rb, 0);
        end
        $display("[TB] round trip mismatches: %0d", fails - rt_fail_before);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
